// File: rtl/ysyx_22041412_axi_master_pkg.sv
// Shared AXI4 encodings and FSM state types for the arbiter-side AXI master bridge.
package ysyx_22041412_axi_master_pkg;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_AR,
        RD_R
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } wr_state_t;

endpackage

// File: rtl/ysyx_22041412_axi_master_size_enc.sv
// Byte-mask to AxSIZE encoder; unrecognised masks fall back to a full doubleword.
module ysyx_22041412_axi_size_enc
    import ysyx_22041412_axi_master_pkg::*;
(
    input  logic [7:0] mask,
    output logic [2:0] size_c
);

    always_comb begin
        size_c = SIZE_D;
        case (mask)
            8'hFF:   size_c = SIZE_D;
            8'h0F:   size_c = SIZE_W;
            8'h03:   size_c = SIZE_H;
            8'h01:   size_c = SIZE_B;
            default: size_c = SIZE_D;
        endcase
    end

endmodule

// File: rtl/ysyx_22041412_axi_master.sv
// AXI4 master bridge: independent read and write engines behind the IF/MEM arbiter.
// Define YSYX_22041412_AXI_RESP_CHECK_EN to latch a sticky error on non-OKAY RRESP/BRESP.
module ysyx_22041412_axi_master
    import ysyx_22041412_axi_master_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      r_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] r_addr_i,
    input  logic [7:0]                r_size_i,
    input  logic [7:0]                r_len_i,
    output logic                      r_ready_o,
    output logic [AXI_DATA_WIDTH-1:0] data_read_o,
    output logic                      r_last_i,

    input  logic                      w_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] w_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0] rw_w_data_i,
    input  logic [7:0]                w_size_i,
    input  logic [7:0]                w_len_i,
    output logic                      w_ready_o,
    output logic                      w_last_i,

    output logic                      axi_ar_valid,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
    output logic [7:0]                axi_ar_len,
    output logic [2:0]                axi_ar_size,
    output logic [1:0]                axi_ar_burst,
    input  logic                      axi_ar_ready,

    input  logic                      axi_r_valid,
    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
    input  logic [1:0]                axi_r_resp,
    input  logic                      axi_r_last,
    input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
    output logic                      axi_r_ready,

    output logic                      axi_aw_valid,
    output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
    output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
    output logic [7:0]                axi_aw_len,
    output logic [2:0]                axi_aw_size,
    output logic [1:0]                axi_aw_burst,
    input  logic                      axi_aw_ready,

    output logic                      axi_w_valid,
    output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
    output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
    output logic                      axi_w_last,
    input  logic                      axi_w_ready,

    input  logic                      axi_b_valid,
    input  logic [1:0]                axi_b_resp,
    input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
    output logic                      axi_b_ready,

    output logic                      axi_err_o
);

    logic [2:0] r_size_enc_c;
    logic [2:0] w_size_enc_c;

    ysyx_22041412_axi_size_enc u_rd_size_enc (.mask(r_size_i), .size_c(r_size_enc_c));
    ysyx_22041412_axi_size_enc u_wr_size_enc (.mask(w_size_i), .size_c(w_size_enc_c));

    assign axi_ar_id    = AXI_ID;
    assign axi_aw_id    = AXI_ID;
    assign axi_ar_burst = BURST_INCR;
    assign axi_aw_burst = BURST_INCR;

    // ---------------- read engine ----------------
    rd_state_t                 rd_state_q, rd_state_d;
    logic                      rd_cancel_q, rd_cancel_d;
    logic                      ar_valid_d, r_ready_axi_d, r_ready_d, r_last_d;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_d;
    logic [7:0]                ar_len_d;
    logic [2:0]                ar_size_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        rd_state_d    = rd_state_q;
        rd_cancel_d   = rd_cancel_q;
        ar_valid_d    = axi_ar_valid;
        ar_addr_d     = axi_ar_addr;
        ar_len_d      = axi_ar_len;
        ar_size_d     = axi_ar_size;
        r_ready_axi_d = axi_r_ready;
        r_ready_d     = 1'b0;
        r_last_d      = 1'b0;
        rdata_d       = data_read_o;
        case (rd_state_q)
            RD_IDLE: begin
                // r_last_i high means upstream has not yet seen the end of the previous burst
                if (r_valid_i && !r_last_i) begin
                    rd_state_d  = RD_AR;
                    rd_cancel_d = 1'b0;
                    ar_valid_d  = 1'b1;
                    ar_addr_d   = r_addr_i;
                    ar_len_d    = r_len_i;
                    ar_size_d   = r_size_enc_c;
                end
            end
            RD_AR: begin
                if (!r_valid_i) rd_cancel_d = 1'b1;
                if (axi_ar_ready) begin
                    ar_valid_d    = 1'b0;
                    r_ready_axi_d = 1'b1;
                    rd_state_d    = RD_R;
                end
            end
            RD_R: begin
                // A cancelled burst is still drained, just never reported upstream
                if (!r_valid_i) rd_cancel_d = 1'b1;
                if (axi_r_valid) begin
                    rdata_d   = axi_r_data;
                    r_ready_d = r_valid_i && !rd_cancel_q;
                    r_last_d  = axi_r_last && r_valid_i && !rd_cancel_q;
                    if (axi_r_last) begin
                        r_ready_axi_d = 1'b0;
                        rd_state_d    = RD_IDLE;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q   <= RD_IDLE;
            rd_cancel_q  <= 1'b0;
            axi_ar_valid <= 1'b0;
            axi_ar_addr  <= '0;
            axi_ar_len   <= '0;
            axi_ar_size  <= '0;
            axi_r_ready  <= 1'b0;
            r_ready_o    <= 1'b0;
            r_last_i     <= 1'b0;
            data_read_o  <= '0;
        end else begin
            rd_state_q   <= rd_state_d;
            rd_cancel_q  <= rd_cancel_d;
            axi_ar_valid <= ar_valid_d;
            axi_ar_addr  <= ar_addr_d;
            axi_ar_len   <= ar_len_d;
            axi_ar_size  <= ar_size_d;
            axi_r_ready  <= r_ready_axi_d;
            r_ready_o    <= r_ready_d;
            r_last_i     <= r_last_d;
            data_read_o  <= rdata_d;
        end
    end

    // ---------------- write engine ----------------
    wr_state_t                 wr_state_q, wr_state_d;
    logic [7:0]                beat_q, beat_d;
    logic                      aw_valid_d, w_valid_d, w_last_d, b_ready_d, w_done_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_d;
    logic [7:0]                aw_len_d;
    logic [2:0]                aw_size_d;
    logic [AXI_STRB_WIDTH-1:0] strb_d;

    always_comb begin
        wr_state_d = wr_state_q;
        beat_d     = beat_q;
        aw_valid_d = axi_aw_valid;
        aw_addr_d  = axi_aw_addr;
        aw_len_d   = axi_aw_len;
        aw_size_d  = axi_aw_size;
        strb_d     = axi_w_strb;
        w_valid_d  = axi_w_valid;
        b_ready_d  = axi_b_ready;
        w_done_d   = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                // w_valid_i is still high in the completion cycle; do not re-accept it
                if (w_valid_i && !w_ready_o) begin
                    wr_state_d = WR_ADDR;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    aw_addr_d  = w_addr_i;
                    aw_len_d   = w_len_i;
                    aw_size_d  = w_size_enc_c;
                    strb_d     = AXI_STRB_WIDTH'(w_size_i);
                    beat_d     = 8'd0;
                end
            end
            WR_ADDR, WR_DATA: begin
                if (axi_w_valid && axi_w_ready) begin
                    if (axi_w_last) w_valid_d = 1'b0;
                    else            beat_d    = beat_q + 8'd1;
                end
                if (axi_aw_valid && axi_aw_ready) aw_valid_d = 1'b0;
                if (!aw_valid_d) begin
                    if (!w_valid_d) begin
                        wr_state_d = WR_RESP;
                        b_ready_d  = 1'b1;
                    end else begin
                        wr_state_d = WR_DATA;
                    end
                end
            end
            WR_RESP: begin
                if (axi_b_valid) begin
                    b_ready_d  = 1'b0;
                    w_done_d   = 1'b1;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
        w_last_d = (beat_d == aw_len_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q   <= WR_IDLE;
            beat_q       <= '0;
            axi_aw_valid <= 1'b0;
            axi_aw_addr  <= '0;
            axi_aw_len   <= '0;
            axi_aw_size  <= '0;
            axi_w_valid  <= 1'b0;
            axi_w_data   <= '0;
            axi_w_strb   <= '0;
            axi_w_last   <= 1'b0;
            axi_b_ready  <= 1'b0;
            w_ready_o    <= 1'b0;
            w_last_i     <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            beat_q       <= beat_d;
            axi_aw_valid <= aw_valid_d;
            axi_aw_addr  <= aw_addr_d;
            axi_aw_len   <= aw_len_d;
            axi_aw_size  <= aw_size_d;
            axi_w_valid  <= w_valid_d;
            axi_w_data   <= rw_w_data_i;
            axi_w_strb   <= strb_d;
            axi_w_last   <= w_last_d;
            axi_b_ready  <= b_ready_d;
            w_ready_o    <= w_done_d;
            w_last_i     <= w_done_d;
        end
    end

    // ---------------- response error flag ----------------
`ifdef YSYX_22041412_AXI_RESP_CHECK_EN
    logic err_d;
    logic unused_id;

    assign unused_id = ^{axi_r_id, axi_b_id};

    always_comb begin
        err_d = axi_err_o;
        if (axi_r_valid && axi_r_ready && (axi_r_resp != RESP_OKAY)) err_d = 1'b1;
        if (axi_b_valid && axi_b_ready && (axi_b_resp != RESP_OKAY)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) axi_err_o <= 1'b0;
        else     axi_err_o <= err_d;
    end
`else
    logic unused_resp_id;

    assign unused_resp_id = ^{axi_r_resp, axi_b_resp, axi_r_id, axi_b_id};
    assign axi_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22041412_axi_master.sv
// Directed self-checking bench for the AXI master bridge; the slave side is driven by hand.
module tb_ysyx_22041412_axi_master;

`ifdef YSYX_22041412_AXI_RESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        r_valid_i;
    logic [31:0] r_addr_i;
    logic [7:0]  r_size_i, r_len_i;
    logic        r_ready_o, r_last_i;
    logic [63:0] data_read_o;
    logic        w_valid_i;
    logic [31:0] w_addr_i;
    logic [63:0] rw_w_data_i;
    logic [7:0]  w_size_i, w_len_i;
    logic        w_ready_o, w_last_i;
    logic        axi_ar_valid, axi_ar_ready;
    logic [31:0] axi_ar_addr;
    logic [3:0]  axi_ar_id;
    logic [7:0]  axi_ar_len;
    logic [2:0]  axi_ar_size;
    logic [1:0]  axi_ar_burst;
    logic        axi_r_valid, axi_r_last, axi_r_ready;
    logic [63:0] axi_r_data;
    logic [1:0]  axi_r_resp;
    logic [3:0]  axi_r_id;
    logic        axi_aw_valid, axi_aw_ready;
    logic [31:0] axi_aw_addr;
    logic [3:0]  axi_aw_id;
    logic [7:0]  axi_aw_len;
    logic [2:0]  axi_aw_size;
    logic [1:0]  axi_aw_burst;
    logic        axi_w_valid, axi_w_last, axi_w_ready;
    logic [63:0] axi_w_data;
    logic [7:0]  axi_w_strb;
    logic        axi_b_valid, axi_b_ready;
    logic [1:0]  axi_b_resp;
    logic [3:0]  axi_b_id;
    logic        axi_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22041412_axi_master dut (
        .clk(clk), .rst(rst),
        .r_valid_i(r_valid_i), .r_addr_i(r_addr_i), .r_size_i(r_size_i), .r_len_i(r_len_i),
        .r_ready_o(r_ready_o), .data_read_o(data_read_o), .r_last_i(r_last_i),
        .w_valid_i(w_valid_i), .w_addr_i(w_addr_i), .rw_w_data_i(rw_w_data_i),
        .w_size_i(w_size_i), .w_len_i(w_len_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .axi_ar_valid(axi_ar_valid), .axi_ar_addr(axi_ar_addr), .axi_ar_id(axi_ar_id),
        .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst),
        .axi_ar_ready(axi_ar_ready),
        .axi_r_valid(axi_r_valid), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
        .axi_r_last(axi_r_last), .axi_r_id(axi_r_id), .axi_r_ready(axi_r_ready),
        .axi_aw_valid(axi_aw_valid), .axi_aw_addr(axi_aw_addr), .axi_aw_id(axi_aw_id),
        .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst),
        .axi_aw_ready(axi_aw_ready),
        .axi_w_valid(axi_w_valid), .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb),
        .axi_w_last(axi_w_last), .axi_w_ready(axi_w_ready),
        .axi_b_valid(axi_b_valid), .axi_b_resp(axi_b_resp), .axi_b_id(axi_b_id),
        .axi_b_ready(axi_b_ready),
        .axi_err_o(axi_err_o)
    );

    task test_reset;
        rst = 1'b1;
        r_valid_i = 0; r_addr_i = 0; r_size_i = 0; r_len_i = 0;
        w_valid_i = 0; w_addr_i = 0; rw_w_data_i = 0; w_size_i = 0; w_len_i = 0;
        axi_ar_ready = 0; axi_r_valid = 0; axi_r_data = 0; axi_r_resp = 0; axi_r_last = 0;
        axi_r_id = 0; axi_aw_ready = 0; axi_w_ready = 0; axi_b_valid = 0; axi_b_resp = 0;
        axi_b_id = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready,
             r_ready_o, r_last_i, w_ready_o, w_last_i, axi_err_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0", {axi_ar_valid, axi_r_ready, axi_aw_valid,
                     axi_w_valid, axi_b_ready, r_ready_o, r_last_i, w_ready_o, w_last_i, axi_err_o});
        end
        checks++;
        if (data_read_o !== 64'd0) begin
            errors++; $display("FAIL reset_data: got %h want 0", data_read_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task test_if_burst;
        logic [63:0] exp_d;
        r_valid_i = 1; r_addr_i = 32'h8000_0000; r_len_i = 8'd3; r_size_i = 8'hFF;
        for (int k = 0; k < 10 && axi_ar_valid !== 1'b1; k++) @(negedge clk);
        checks++;
        if (axi_ar_valid !== 1'b1) begin errors++; $display("FAIL if_arvalid: got %b want 1", axi_ar_valid); end
        checks++;
        if ({axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id} !== {32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd0}) begin
            errors++;
            $display("FAIL if_ar_fields: got addr=%h len=%0d size=%0d burst=%0d id=%0d want 80000000/3/3/1/0",
                     axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id);
        end
        repeat (2) @(negedge clk);
        axi_ar_ready = 1;
        @(negedge clk);
        axi_ar_ready = 0;
        checks++;
        if ({axi_ar_valid, axi_r_ready} !== 2'b01) begin
            errors++; $display("FAIL if_ar_hs: got ar_valid/r_ready=%b want 01", {axi_ar_valid, axi_r_ready});
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = 64'h0123_4567_89AB_CDE0 + 64'(i);
            axi_r_valid = 1; axi_r_data = exp_d; axi_r_last = (i == 3);
            @(negedge clk);
            axi_r_valid = 0; axi_r_last = 0;
            checks++;
            if ({r_ready_o, r_last_i} !== {1'b1, 1'(i == 3)} || data_read_o !== exp_d) begin
                errors++;
                $display("FAIL if_beat%0d: got rdy=%b last=%b data=%h want 1/%0d/%h",
                         i, r_ready_o, r_last_i, data_read_o, (i == 3), exp_d);
            end
        end
        r_valid_i = 0;
        @(negedge clk);
        checks++;
        if ({r_ready_o, r_last_i, axi_r_ready, axi_ar_valid} !== 4'b0) begin
            errors++; $display("FAIL if_end: got %b want 0000", {r_ready_o, r_last_i, axi_r_ready, axi_ar_valid});
        end
    endtask

    task test_backpressure;
        r_valid_i = 1; r_addr_i = 32'h8000_0100; r_len_i = 8'd0; r_size_i = 8'h03;
        for (int k = 0; k < 10 && axi_ar_valid !== 1'b1; k++) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (axi_ar_valid !== 1'b1 || axi_ar_addr !== 32'h8000_0100 || axi_ar_size !== 3'd1) begin
                errors++;
                $display("FAIL bp_stable%0d: got valid=%b addr=%h size=%0d want 1/80000100/1",
                         c, axi_ar_valid, axi_ar_addr, axi_ar_size);
            end
            @(negedge clk);
        end
        axi_ar_ready = 1;
        @(negedge clk);
        axi_ar_ready = 0;
        axi_r_valid = 1; axi_r_data = 64'h0000_0000_0000_BEEF; axi_r_last = 1;
        @(negedge clk);
        axi_r_valid = 0; axi_r_last = 0;
        checks++;
        if ({r_ready_o, r_last_i} !== 2'b11 || data_read_o !== 64'h0000_0000_0000_BEEF) begin
            errors++; $display("FAIL bp_beat: got rdy=%b last=%b data=%h want 1/1/beef", r_ready_o, r_last_i, data_read_o);
        end
        r_valid_i = 0;
        @(negedge clk);
    endtask

    task test_mem_write;
        w_valid_i = 1; w_addr_i = 32'h8000_1004; w_size_i = 8'h0F; w_len_i = 8'd0;
        rw_w_data_i = 64'h0000_0000_1234_5678;
        for (int k = 0; k < 10 && axi_aw_valid !== 1'b1; k++) @(negedge clk);
        checks++;
        if ({axi_aw_valid, axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst} !== {1'b1, 32'h8000_1004, 8'd0, 3'd2, 2'b01}) begin
            errors++;
            $display("FAIL mw_aw: got v=%b addr=%h len=%0d size=%0d burst=%0d want 1/80001004/0/2/1",
                     axi_aw_valid, axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst);
        end
        checks++;
        if ({axi_w_valid, axi_w_strb, axi_w_last} !== {1'b1, 8'h0F, 1'b1} || axi_w_data !== 64'h0000_0000_1234_5678) begin
            errors++;
            $display("FAIL mw_w: got v=%b strb=%h last=%b data=%h want 1/0f/1/12345678",
                     axi_w_valid, axi_w_strb, axi_w_last, axi_w_data);
        end
        axi_aw_ready = 1;
        @(negedge clk);
        axi_aw_ready = 0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({axi_aw_valid, axi_w_valid, axi_b_ready} !== 3'b010) begin
                errors++; $display("FAIL mw_wait%0d: got aw/w/b=%b want 010", c, {axi_aw_valid, axi_w_valid, axi_b_ready});
            end
            if (c < 2) @(negedge clk);
        end
        axi_w_ready = 1;
        @(negedge clk);
        axi_w_ready = 0;
        checks++;
        if ({axi_w_valid, axi_b_ready, w_ready_o} !== 3'b010) begin
            errors++; $display("FAIL mw_resp: got w/b/wrdy=%b want 010", {axi_w_valid, axi_b_ready, w_ready_o});
        end
        axi_b_valid = 1; axi_b_resp = 2'b00;
        @(negedge clk);
        axi_b_valid = 0;
        checks++;
        if ({w_ready_o, w_last_i, axi_b_ready} !== 3'b110) begin
            errors++; $display("FAIL mw_done: got wrdy/wlast/bready=%b want 110", {w_ready_o, w_last_i, axi_b_ready});
        end
        w_valid_i = 0;
        @(negedge clk);
        checks++;
        if ({w_ready_o, w_last_i, axi_aw_valid, axi_w_valid} !== 4'b0) begin
            errors++; $display("FAIL mw_once: got %b want 0000", {w_ready_o, w_last_i, axi_aw_valid, axi_w_valid});
        end
    endtask

    task test_overlap;
        logic [63:0] exp_d;
        r_valid_i = 1; r_addr_i = 32'h8000_2000; r_len_i = 8'd3; r_size_i = 8'hFF;
        w_valid_i = 1; w_addr_i = 32'h8000_3008; w_size_i = 8'hFF; w_len_i = 8'd0;
        rw_w_data_i = 64'hCAFE_F00D_DEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({axi_ar_valid, axi_aw_valid, axi_w_valid} !== 3'b111) begin
            errors++; $display("FAIL ov_issue: got ar/aw/w=%b want 111", {axi_ar_valid, axi_aw_valid, axi_w_valid});
        end
        axi_ar_ready = 1; axi_aw_ready = 1; axi_w_ready = 1;
        @(negedge clk);
        axi_ar_ready = 0; axi_aw_ready = 0; axi_w_ready = 0;
        checks++;
        if ({axi_ar_valid, axi_aw_valid, axi_w_valid, axi_r_ready, axi_b_ready} !== 5'b00011) begin
            errors++;
            $display("FAIL ov_hs: got %b want 00011", {axi_ar_valid, axi_aw_valid, axi_w_valid, axi_r_ready, axi_b_ready});
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = 64'h5500_0000_0000_0010 + 64'(i);
            axi_r_valid = 1; axi_r_data = exp_d; axi_r_last = (i == 3);
            axi_b_valid = (i == 1); axi_b_resp = 2'b00;
            @(negedge clk);
            axi_r_valid = 0; axi_r_last = 0; axi_b_valid = 0;
            checks++;
            if ({r_ready_o, r_last_i, w_ready_o} !== {1'b1, 1'(i == 3), 1'(i == 1)} || data_read_o !== exp_d) begin
                errors++;
                $display("FAIL ov_beat%0d: got rrdy=%b rlast=%b wrdy=%b data=%h want 1/%0d/%0d/%h",
                         i, r_ready_o, r_last_i, w_ready_o, data_read_o, (i == 3), (i == 1), exp_d);
            end
            if (i == 1) w_valid_i = 0;
        end
        r_valid_i = 0;
        @(negedge clk);
    endtask

    task test_cancel;
        r_valid_i = 1; r_addr_i = 32'h8000_4000; r_len_i = 8'd1; r_size_i = 8'hFF;
        for (int k = 0; k < 10 && axi_ar_valid !== 1'b1; k++) @(negedge clk);
        axi_ar_ready = 1;
        @(negedge clk);
        axi_ar_ready = 0;
        r_valid_i = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (axi_r_ready !== 1'b1) begin
                errors++; $display("FAIL cancel_rready%0d: got %b want 1", i, axi_r_ready);
            end
            axi_r_valid = 1; axi_r_data = 64'h77 + 64'(i); axi_r_last = (i == 1);
            @(negedge clk);
            axi_r_valid = 0; axi_r_last = 0;
            checks++;
            if ({r_ready_o, r_last_i} !== 2'b00) begin
                errors++; $display("FAIL cancel_beat%0d: got rdy/last=%b want 00", i, {r_ready_o, r_last_i});
            end
        end
        @(negedge clk);
        checks++;
        if ({axi_r_ready, axi_ar_valid, r_ready_o} !== 3'b000) begin
            errors++; $display("FAIL cancel_idle: got rready/arvalid/rrdy=%b want 000", {axi_r_ready, axi_ar_valid, r_ready_o});
        end
    endtask

    task test_resp_err;
        w_valid_i = 1; w_addr_i = 32'h8000_5000; w_size_i = 8'h01; w_len_i = 8'd0; rw_w_data_i = 64'h5A;
        for (int k = 0; k < 10 && axi_aw_valid !== 1'b1; k++) @(negedge clk);
        checks++;
        if ({axi_aw_size, axi_w_strb} !== {3'd0, 8'h01}) begin
            errors++; $display("FAIL err_fields: got size=%0d strb=%h want 0/01", axi_aw_size, axi_w_strb);
        end
        axi_aw_ready = 1; axi_w_ready = 1;
        @(negedge clk);
        axi_aw_ready = 0; axi_w_ready = 0;
        axi_b_valid = 1; axi_b_resp = 2'b10;
        @(negedge clk);
        axi_b_valid = 0; axi_b_resp = 2'b00;
        checks++;
        if ({w_ready_o, axi_err_o} !== {1'b1, EXP_ERR}) begin
            errors++; $display("FAIL err_set: got wrdy=%b err=%b want 1/%b", w_ready_o, axi_err_o, EXP_ERR);
        end
        w_valid_i = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (axi_err_o !== EXP_ERR) begin
            errors++; $display("FAIL err_sticky: got %b want %b", axi_err_o, EXP_ERR);
        end
    endtask

    task test_reset_mid;
        r_valid_i = 1; r_addr_i = 32'h8000_6000; r_len_i = 8'd3; r_size_i = 8'hFF;
        w_valid_i = 1; w_addr_i = 32'h8000_7000; w_size_i = 8'hFF; w_len_i = 8'd0;
        @(negedge clk);
        axi_ar_ready = 1;
        @(negedge clk);
        axi_ar_ready = 0;
        axi_r_valid = 1; axi_r_data = 64'h1111_2222_3333_4444; axi_r_last = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        checks++;
        if ({axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready,
             r_ready_o, r_last_i, w_ready_o, w_last_i, axi_err_o} !== 10'b0 || data_read_o !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid: got ctrl=%b data=%h want 0/0", {axi_ar_valid, axi_r_ready, axi_aw_valid,
                     axi_w_valid, axi_b_ready, r_ready_o, r_last_i, w_ready_o, w_last_i, axi_err_o}, data_read_o);
        end
        rst = 0; axi_r_valid = 0; r_valid_i = 0; w_valid_i = 0;
        @(negedge clk);
        checks++;
        if ({axi_ar_valid, axi_aw_valid, axi_r_ready} !== 3'b000) begin
            errors++; $display("FAIL rst_idle: got %b want 000", {axi_ar_valid, axi_aw_valid, axi_r_ready});
        end
    endtask

    initial begin
        test_reset;
        test_if_burst;
        test_backpressure;
        test_mem_write;
        test_overlap;
        test_cancel;
        test_resp_err;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
